// File: rtl/sound_decoder_if.sv
// Signal bundle between the audio line / timebase and the tone decoder.
interface sound_decoder_if;
  logic       hsync;
  logic       vsync;
  logic       audio;
  logic       tone_valid;
  logic [1:0] tone_id;
  logic [3:0] event_pulse;
  logic [3:0] burst_frames;
  logic       burst_done;

  modport master (
    output hsync, vsync, audio,
    input  tone_valid, tone_id, event_pulse, burst_frames, burst_done
  );

  modport slave (
    input  hsync, vsync, audio,
    output tone_valid, tone_id, event_pulse, burst_frames, burst_done
  );
endinterface

// File: rtl/sound_decoder.sv
// Tone decoder: measures audio half-periods in hsync lines and locks onto tick/failure/eat/success.
// Define SOUND_DECODER_DURATION_EN to build the locked-burst frame counter (burst_frames/burst_done).
module sound_decoder #(
  parameter int unsigned MATCH_COUNT   = 3,
  parameter int unsigned TOL           = 2,
  parameter int unsigned SILENCE_LINES = 320
) (
  input  logic           clk,
  input  logic           rst_n,
  sound_decoder_if.slave snd
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [8:0] NOMINAL [4] = '{9'd101, 9'd151, 9'd201, 9'd251};

  state_e     state_q, state_d;
  logic       prev_hsync_q, prev_audio_q;
  logic [8:0] line_cnt_q, line_cnt_d;
  logic [8:0] half_len_q;
  logic       toggle_q;
  logic [1:0] match_cnt_q, match_cnt_d;
  logic [1:0] cand_id_q, cand_id_d;
  logic [1:0] tone_id_q, tone_id_d;
  logic       tone_valid_q, tone_valid_d;
  logic [3:0] event_pulse_q, event_pulse_d;

  logic       hsync_rise_s, toggle_s, silence_s, cls_valid_s;
  logic [1:0] cls_id_s;
  logic [2:0] match_next_s;

  function automatic logic [2:0] classify(input logic [8:0] len);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 0; k < 4; k++) begin
      if ((({1'b0, len} + 10'(TOL)) >= {1'b0, NOMINAL[k]}) &&
          ({1'b0, len} <= ({1'b0, NOMINAL[k]} + 10'(TOL)))) begin
        res = {1'b1, 2'(k)};
      end
    end
    return res;
  endfunction

  assign hsync_rise_s = snd.hsync && !prev_hsync_q;
  assign toggle_s     = snd.audio != prev_audio_q;
  assign silence_s    = (line_cnt_q >= 9'(SILENCE_LINES)) && !toggle_s;
  assign {cls_valid_s, cls_id_s} = classify(half_len_q);
  assign match_next_s = ((cls_id_s == cand_id_q) && (match_cnt_q != 2'd0)) ?
                        ({1'b0, match_cnt_q} + 3'd1) : 3'd1;

  // Line counter; an hsync edge coincident with a toggle belongs to the new interval.
  always_comb begin
    line_cnt_d = line_cnt_q;
    if (toggle_s) begin
      line_cnt_d = hsync_rise_s ? 9'd1 : 9'd0;
    end else if (hsync_rise_s && (line_cnt_q != 9'd511)) begin
      line_cnt_d = line_cnt_q + 9'd1;
    end else begin
      line_cnt_d = line_cnt_q;
    end
  end

  // Lock FSM, acting on the half-period captured in the previous cycle.
  always_comb begin
    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    cand_id_d     = cand_id_q;
    tone_valid_d  = tone_valid_q;
    tone_id_d     = tone_id_q;
    event_pulse_d = 4'b0000;
    if (silence_s) begin
      state_d      = IDLE;
      match_cnt_d  = 2'd0;
      tone_valid_d = 1'b0;
    end else if (toggle_q) begin
      case (state_q)
        IDLE: begin
          state_d     = MEASURE;
          match_cnt_d = 2'd0;
        end
        MEASURE: begin
          if (cls_valid_s) begin
            cand_id_d   = cls_id_s;
            match_cnt_d = match_next_s[1:0];
            if (match_next_s == 3'(MATCH_COUNT)) begin
              state_d       = LOCKED;
              tone_valid_d  = 1'b1;
              tone_id_d     = cls_id_s;
              event_pulse_d = 4'b0001 << cls_id_s;
            end else begin
              state_d = MEASURE;
            end
          end else begin
            match_cnt_d = 2'd0;
          end
        end
        LOCKED: begin
          if (!cls_valid_s) begin
            state_d      = MEASURE;
            match_cnt_d  = 2'd0;
            tone_valid_d = 1'b0;
          end else if (cls_id_s != cand_id_q) begin
            state_d      = MEASURE;
            cand_id_d    = cls_id_s;
            match_cnt_d  = 2'd1;
            tone_valid_d = 1'b0;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d      = IDLE;
          match_cnt_d  = 2'd0;
          tone_valid_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Core state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prev_hsync_q  <= 1'b0;
      prev_audio_q  <= 1'b0;
      line_cnt_q    <= 9'd0;
      half_len_q    <= 9'd0;
      toggle_q      <= 1'b0;
      match_cnt_q   <= 2'd0;
      cand_id_q     <= 2'd0;
      tone_id_q     <= 2'd0;
      tone_valid_q  <= 1'b0;
      event_pulse_q <= 4'b0000;
    end else begin
      state_q       <= state_d;
      prev_hsync_q  <= snd.hsync;
      prev_audio_q  <= snd.audio;
      line_cnt_q    <= line_cnt_d;
      half_len_q    <= toggle_s ? line_cnt_q : half_len_q;
      toggle_q      <= toggle_s;
      match_cnt_q   <= match_cnt_d;
      cand_id_q     <= cand_id_d;
      tone_id_q     <= tone_id_d;
      tone_valid_q  <= tone_valid_d;
      event_pulse_q <= event_pulse_d;
    end
  end

  assign snd.tone_valid  = tone_valid_q;
  assign snd.tone_id     = tone_id_q;
  assign snd.event_pulse = event_pulse_q;

`ifdef SOUND_DECODER_DURATION_EN
  logic       prev_vsync_q;
  logic       vsync_rise_s;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] burst_frames_q, burst_frames_d;
  logic       burst_done_q, burst_done_d;

  assign vsync_rise_s = snd.vsync && !prev_vsync_q;

  // Frames spent locked, reported on every non-reset exit from LOCKED.
  always_comb begin
    frame_cnt_d    = frame_cnt_q;
    burst_frames_d = burst_frames_q;
    burst_done_d   = 1'b0;
    if ((state_d == LOCKED) && (state_q != LOCKED)) begin
      frame_cnt_d = 4'd0;
    end else if ((state_q == LOCKED) && vsync_rise_s && (frame_cnt_q != 4'hF)) begin
      frame_cnt_d = frame_cnt_q + 4'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if ((state_q == LOCKED) && (state_d != LOCKED)) begin
      burst_frames_d = frame_cnt_q;
      burst_done_d   = 1'b1;
    end else begin
      burst_done_d = 1'b0;
    end
  end

  // Burst-duration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_vsync_q   <= 1'b0;
      frame_cnt_q    <= 4'd0;
      burst_frames_q <= 4'd0;
      burst_done_q   <= 1'b0;
    end else begin
      prev_vsync_q   <= snd.vsync;
      frame_cnt_q    <= frame_cnt_d;
      burst_frames_q <= burst_frames_d;
      burst_done_q   <= burst_done_d;
    end
  end

  assign snd.burst_frames = burst_frames_q;
  assign snd.burst_done   = burst_done_q;
`else
  assign snd.burst_frames = 4'd0;
  assign snd.burst_done   = 1'b0;
`endif

endmodule

// File: tb/tb_sound_decoder.sv
// Directed bench for sound_decoder: table of half-period vectors plus hand sequences for silence and reset.
module tb_sound_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   prev_coinc;

  sound_decoder_if snd ();

  sound_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .snd   (snd)
  );

  typedef struct {
    int         len;
    bit         coinc;
    bit         exp_valid;
    logic [1:0] exp_id;
    logic [3:0] exp_pulse;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  logic [3:0] exp_frames;
  logic       exp_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one clock cycle of inputs starting at a falling edge.
  task automatic cyc(input bit h, input bit tog, input bit v);
    snd.hsync = h;
    snd.vsync = v;
    if (tog) snd.audio = ~snd.audio;
    @(negedge clk);
  endtask

  task automatic line(input bit tog_a, input bit tog_b);
    cyc(1'b1, tog_a, 1'b0);
    cyc(1'b0, tog_b, 1'b0);
  endtask

  // One half-period of len lines; returns two cycles after the toggle cycle.
  task automatic run_half(input int len, input bit coinc);
    int n;
    n = prev_coinc ? len - 1 : len;
    if (coinc) begin
      repeat (n) line(1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
    end else begin
      repeat (n - 1) line(1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    prev_coinc = coinc;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    prev_coinc = 1'b0;
`ifdef SOUND_DECODER_DURATION_EN
    exp_frames = 4'd4;
    exp_done   = 1'b1;
`else
    exp_frames = 4'd0;
    exp_done   = 1'b0;
`endif

    vecs[0]  = '{101, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[1]  = '{101, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[2]  = '{101, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[3]  = '{101, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[4]  = '{101, 1'b0, 1'b1, 2'd0, 4'b0000};
    vecs[5]  = '{330, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[6]  = '{249, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[7]  = '{253, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[8]  = '{254, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[9]  = '{251, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[10] = '{251, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[11] = '{251, 1'b0, 1'b1, 2'd3, 4'b1000};
    vecs[12] = '{201, 1'b0, 1'b0, 2'd3, 4'b0000};
    vecs[13] = '{201, 1'b0, 1'b0, 2'd3, 4'b0000};
    vecs[14] = '{201, 1'b0, 1'b1, 2'd2, 4'b0100};
    vecs[15] = '{151, 1'b0, 1'b0, 2'd2, 4'b0000};
    vecs[16] = '{151, 1'b0, 1'b0, 2'd2, 4'b0000};
    vecs[17] = '{151, 1'b0, 1'b1, 2'd1, 4'b0010};
    vecs[18] = '{330, 1'b0, 1'b0, 2'd1, 4'b0000};
    vecs[19] = '{103, 1'b1, 1'b0, 2'd1, 4'b0000};
    vecs[20] = '{99,  1'b1, 1'b0, 2'd1, 4'b0000};
    vecs[21] = '{99,  1'b1, 1'b1, 2'd0, 4'b0001};
    vecs[22] = '{101, 1'b0, 1'b1, 2'd0, 4'b0000};
    vecs[23] = '{320, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[24] = '{101, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[25] = '{101, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[26] = '{101, 1'b0, 1'b1, 2'd0, 4'b0001};
    vecs[27] = '{151, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[28] = '{151, 1'b0, 1'b0, 2'd0, 4'b0000};
    vecs[29] = '{151, 1'b0, 1'b1, 2'd1, 4'b0010};

    rst_n     = 1'b0;
    snd.hsync = 1'b0;
    snd.vsync = 1'b0;
    snd.audio = 1'b0;
    @(negedge clk);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("rst_valid", 8'(snd.tone_valid), 8'd0);
    chk("rst_id", 8'(snd.tone_id), 8'd0);
    chk("rst_pulse", 8'(snd.event_pulse), 8'd0);
    chk("rst_frames", 8'(snd.burst_frames), 8'd0);
    chk("rst_done", 8'(snd.burst_done), 8'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      run_half(vecs[i].len, vecs[i].coinc);
      chk($sformatf("v%0d_valid", i), 8'(snd.tone_valid), 8'(vecs[i].exp_valid));
      chk($sformatf("v%0d_id", i), 8'(snd.tone_id), 8'(vecs[i].exp_id));
      chk($sformatf("v%0d_pulse", i), 8'(snd.event_pulse), 8'(vecs[i].exp_pulse));
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_pulse_gone", i), 8'(snd.event_pulse), 8'd0);
    end

    // Locked on failure: four frames, then silence.
    repeat (4) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end
    repeat (319) line(1'b0, 1'b0);
    chk("sil_319_valid", 8'(snd.tone_valid), 8'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("sil_320_valid", 8'(snd.tone_valid), 8'd1);
    chk("sil_320_done", 8'(snd.burst_done), 8'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("sil_drop_valid", 8'(snd.tone_valid), 8'd0);
    chk("sil_hold_id", 8'(snd.tone_id), 8'd1);
    chk("sil_done", 8'(snd.burst_done), 8'(exp_done));
    chk("sil_frames", 8'(snd.burst_frames), 8'(exp_frames));
    cyc(1'b0, 1'b0, 1'b0);
    chk("sil_done_gone", 8'(snd.burst_done), 8'd0);
    chk("sil_frames_hold", 8'(snd.burst_frames), 8'(exp_frames));

    // Relock on eat, then a single-cycle reset.
    repeat (4) run_half(201, 1'b0);
    chk("relock_valid", 8'(snd.tone_valid), 8'd1);
    chk("relock_id", 8'(snd.tone_id), 8'd2);
    chk("relock_pulse", 8'(snd.event_pulse), 8'b0100);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("mid_rst_valid", 8'(snd.tone_valid), 8'd0);
    chk("mid_rst_id", 8'(snd.tone_id), 8'd0);
    chk("mid_rst_pulse", 8'(snd.event_pulse), 8'd0);
    chk("mid_rst_frames", 8'(snd.burst_frames), 8'd0);
    chk("mid_rst_done", 8'(snd.burst_done), 8'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_valid", 8'(snd.tone_valid), 8'd0);
    chk("post_rst_pulse", 8'(snd.event_pulse), 8'd0);
    chk("post_rst_done", 8'(snd.burst_done), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
